// File: rtl/panel_scan_if.sv
// Panel reader signal bundle: shift-register drive/return plus debounced key outputs.
// Latency: wires only; no backpressure, the consumer samples levels and pulses directly.
interface panel_scan_if #(
  parameter int NUM_BITS = 24
);
  logic                sclk;
  logic                sload_n;
  logic                sdata;
  logic [NUM_BITS-1:0] keys;
  logic [NUM_BITS-1:0] key_pressed;
  logic [NUM_BITS-1:0] key_released;
  logic                scan_done;
  logic                keysValid;

  modport master (
    output sclk, sload_n, keys, key_pressed, key_released, scan_done, keysValid,
    input  sdata
  );

  modport slave (
    input  sclk, sload_n, keys, key_pressed, key_released, scan_done, keysValid,
    output sdata
  );
endinterface

// File: rtl/panel_scan.sv
// Scans a 74HC165 chain each scan period and debounces every bit across scans.
// Latency: keys/pulses one cycle after UPDATE; no backpressure, pulses are fire-and-forget.
module panel_scan #(
  parameter int NUM_BITS       = 24,
  parameter int CLK_DIV        = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SCAN_GAP       = 1024,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  panel_scan_if.master io_pnl
);

  localparam int         CMAX   = (CLK_DIV > SCAN_GAP) ? CLK_DIV : SCAN_GAP;
  localparam int         CW     = $clog2(CMAX + 1);
  localparam int         BW     = $clog2(NUM_BITS + 1);
  localparam logic [3:0] DB_THR = 4'(DEBOUNCE_SCANS);

  typedef enum logic [2:0] {
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    UPDATE,
    GAP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bit;
  logic                w_div_end;
  logic                w_gap_end;
  logic                w_last_bit;
  logic                w_sample;
  logic                w_bit_in;

  logic                r_sd_meta;
  logic                r_sd_sync;
  logic [NUM_BITS-1:0] r_raw;

  logic                r_sclk;
  logic                r_sload_n;
  logic [NUM_BITS-1:0] r_keys;
  logic [NUM_BITS-1:0] r_pressed;
  logic [NUM_BITS-1:0] r_released;
  logic                r_scan_done;
  logic                r_keys_vld;
  logic [3:0]          r_scan_cnt;
  logic [3:0]          r_db_cnt [NUM_BITS];

  assign w_div_end  = (r_cnt == CW'(CLK_DIV - 1));
  assign w_gap_end  = (r_cnt == CW'(SCAN_GAP - 1));
  assign w_last_bit = (r_bit == BW'(NUM_BITS - 1));
  assign w_bit_in   = (ACTIVE_LOW != 0) ? ~r_sd_sync : r_sd_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_div_end) w_next = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (w_div_end) begin
          w_sample = 1'b1;
          w_next   = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (w_div_end) w_next = w_last_bit ? UPDATE : SHIFT_LO;
      end
      UPDATE: begin
        w_next = GAP;
      end
      GAP: begin
        if (w_gap_end) w_next = LOAD;
      end
      default: begin
        w_next = LOAD;
      end
    endcase
  end

  // Phase counter restarts on every state change, so each phase times itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      if (r_state == SHIFT_HI && w_div_end) begin
        r_bit <= w_last_bit ? '0 : r_bit + BW'(1);
      end
    end
  end

  // Pins lag the state by one cycle; sampling at the end of LO stays well clear of the next shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sd_meta <= 1'(ACTIVE_LOW);
      r_sd_sync <= 1'(ACTIVE_LOW);
      r_raw     <= '0;
      r_sclk    <= 1'b0;
      r_sload_n <= 1'b1;
    end else begin
      r_sd_meta <= io_pnl.sdata;
      r_sd_sync <= r_sd_meta;
      if (w_sample) r_raw <= {r_raw[NUM_BITS-2:0], w_bit_in};
      r_sclk    <= (r_state == SHIFT_HI);
      r_sload_n <= (r_state != LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keys      <= '0;
      r_pressed   <= '0;
      r_released  <= '0;
      r_scan_done <= 1'b0;
      r_keys_vld  <= 1'b0;
      r_scan_cnt  <= '0;
      for (int i = 0; i < NUM_BITS; i++) r_db_cnt[i] <= '0;
    end else begin
      r_pressed   <= '0;
      r_released  <= '0;
      r_scan_done <= 1'b0;
      if (r_state == UPDATE) begin
        r_scan_done <= 1'b1;
        if (r_scan_cnt != DB_THR) r_scan_cnt <= r_scan_cnt + 4'd1;
        if (r_scan_cnt + 4'd1 == DB_THR) r_keys_vld <= 1'b1;
        for (int i = 0; i < NUM_BITS; i++) begin
          if (r_raw[i] == r_keys[i]) begin
            r_db_cnt[i] <= '0;
          end else if (r_db_cnt[i] + 4'd1 == DB_THR) begin
            r_keys[i]     <= ~r_keys[i];
            r_db_cnt[i]   <= '0;
            r_pressed[i]  <= r_raw[i];
            r_released[i] <= ~r_raw[i];
          end else if (r_db_cnt[i] != 4'hF) begin
            r_db_cnt[i] <= r_db_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  assign io_pnl.sclk         = r_sclk;
  assign io_pnl.sload_n      = r_sload_n;
  assign io_pnl.keys         = r_keys;
  assign io_pnl.key_pressed  = r_pressed;
  assign io_pnl.key_released = r_released;
  assign io_pnl.scan_done    = r_scan_done;
  assign io_pnl.keysValid    = r_keys_vld;

endmodule

// File: tb/tb_panel_scan.sv
// Directed bench for panel_scan with a behavioural 74HC165 chain model on the panel side.
module tb_panel_scan;
  localparam int NB = 24;

  logic clk;
  logic rst_n;
  logic [NB-1:0] pressed;
  logic [NB-1:0] sreg;
  logic sclk_q;

  int n_checks;
  int n_pass;
  int cyc;
  int last_fall;
  int have_fall;
  int period;
  int low_w;
  int rises;
  logic prev_sload;
  logic prev_sclk;

  panel_scan_if #(.NUM_BITS(NB)) pif ();

  panel_scan #(
    .NUM_BITS(NB), .CLK_DIV(16), .DEBOUNCE_SCANS(4), .SCAN_GAP(1024), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_pnl(pif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low panel: pressed switch pulls its input to 0.
  always @(posedge clk) begin
    if (!pif.sload_n) sreg <= ~pressed;
    else if (pif.sclk && !sclk_q) sreg <= {sreg[NB-2:0], 1'b1};
    sclk_q <= pif.sclk;
  end
  assign pif.sdata = sreg[NB-1];

  initial begin
    cyc = 0; last_fall = 0; have_fall = 0; period = 0; low_w = 0; rises = 0;
    prev_sload = 1'b1; prev_sclk = 1'b0; sreg = '1; sclk_q = 1'b0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      have_fall = 0;
    end else begin
      if (prev_sload && !pif.sload_n) begin
        if (have_fall != 0) period = cyc - last_fall;
        last_fall = cyc;
        have_fall = 1;
        rises = 0;
        low_w = 0;
      end
      if (!pif.sload_n) low_w = low_w + 1;
      if (!prev_sclk && pif.sclk) rises = rises + 1;
    end
    prev_sload = pif.sload_n;
    prev_sclk  = pif.sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass = n_pass + 1;
  endtask

  task automatic wait_scan();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pif.scan_done && n < 4000);
    if (!pif.scan_done) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  // Parks mid-SHIFT with sclk high, about halfway through the chain.
  task automatic wait_mid_shift();
    int n;
    n = 0;
    while (pif.sload_n && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!(rises >= 12 && pif.sclk) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_shift_sclk_hi", {31'd0, pif.sclk}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    pressed  = '0;
    repeat (3) @(negedge clk);
    chk("rst_sclk",     {31'd0, pif.sclk},      32'd0);
    chk("rst_sload_n",  {31'd0, pif.sload_n},   32'd1);
    chk("rst_keys",     32'(pif.keys),          32'd0);
    chk("rst_pressed",  32'(pif.key_pressed),   32'd0);
    chk("rst_released", 32'(pif.key_released), 32'd0);
    chk("rst_done",     {31'd0, pif.scan_done}, 32'd0);
    chk("rst_valid",    {31'd0, pif.keysValid}, 32'd0);

    pressed = 24'hA50F3C;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_load", {31'd0, pif.sload_n}, 32'd0);
    wait_scan();
    chk("s1_keys",     32'(pif.keys),          32'd0);
    chk("s1_valid",    {31'd0, pif.keysValid}, 32'd0);
    chk("sload_low_w", low_w,                  32'd16);
    chk("sclk_rises",  rises,                  32'd24);

    wait_mid_shift();
    rst_n = 1'b0;
    #1;
    chk("arst_sclk",    {31'd0, pif.sclk},      32'd0);
    chk("arst_sload_n", {31'd0, pif.sload_n},   32'd1);
    chk("arst_keys",    32'(pif.keys),          32'd0);
    chk("arst_done",    {31'd0, pif.scan_done}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_first_load", {31'd0, pif.sload_n}, 32'd0);

    wait_scan();
    wait_scan();
    chk("scan_period", period, 32'd1809);
    wait_scan();
    chk("s3_keys",  32'(pif.keys),          32'd0);
    chk("s3_valid", {31'd0, pif.keysValid}, 32'd0);
    wait_scan();
    chk("s4_keys",     32'(pif.keys),          32'hA50F3C);
    chk("s4_valid",    {31'd0, pif.keysValid}, 32'd1);
    chk("s4_pressed",  32'(pif.key_pressed),   32'hA50F3C);
    chk("s4_released", 32'(pif.key_released),  32'd0);
    @(negedge clk);
    chk("s4_pulse_end", 32'(pif.key_pressed),   32'd0);
    chk("s4_done_end",  {31'd0, pif.scan_done}, 32'd0);

    pressed = '0;
    repeat (3) wait_scan();
    chk("rel_s3_keys", 32'(pif.keys), 32'hA50F3C);
    wait_scan();
    chk("rel_keys",     32'(pif.keys),         32'd0);
    chk("rel_released", 32'(pif.key_released), 32'hA50F3C);
    chk("rel_pressed",  32'(pif.key_pressed),  32'd0);

    for (int s = 0; s < 7; s++) begin
      pressed = (s == 3) ? 24'h0 : 24'h000020;
      wait_scan();
      chk("glitch_keys",  32'(pif.keys),                           32'd0);
      chk("glitch_pulse", 32'(pif.key_pressed | pif.key_released), 32'd0);
    end

    pressed = 24'h801001;
    repeat (3) wait_scan();
    chk("multi_s3_keys", 32'(pif.keys), 32'd0);
    wait_scan();
    chk("multi_keys",     32'(pif.keys),         32'h801001);
    chk("multi_pressed",  32'(pif.key_pressed),  32'h801001);
    chk("multi_released", 32'(pif.key_released), 32'd0);
    wait_scan();
    chk("multi_hold_pulse", 32'(pif.key_pressed), 32'd0);
    chk("multi_hold_keys",  32'(pif.keys),        32'h801001);

    pressed = '0;
    repeat (3) wait_scan();
    chk("mrel_s3_keys", 32'(pif.keys), 32'h801001);
    wait_scan();
    chk("mrel_keys",     32'(pif.keys),         32'd0);
    chk("mrel_released", 32'(pif.key_released), 32'h801001);
    chk("mrel_pressed",  32'(pif.key_pressed),  32'd0);

    chk("pre_rst_valid", {31'd0, pif.keysValid}, 32'd1);
    wait_mid_shift();
    rst_n = 1'b0;
    #1;
    chk("arst2_valid", {31'd0, pif.keysValid}, 32'd0);
    chk("arst2_sclk",  {31'd0, pif.sclk},      32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_first_load", {31'd0, pif.sload_n}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
